max_pool_2x2: RTL



---
 rtl/max_pool_2x2_if.sv | 27 ++
 rtl/max_pool_2x2.sv | 86 ++++++++
 2 files changed

// File: rtl/max_pool_2x2_if.sv
// Pixel stream bundle between the convolver side and the pooler.
// The master drives input beats; the slave returns pooled pixels.
interface max_pool_2x2_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic [DATA_WIDTH-1:0] pool_out;
    logic                  valid_pool;
    logic                  end_pool;

    modport master (
        output in_valid,
        output in_data,
        input  pool_out,
        input  valid_pool,
        input  end_pool
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output pool_out,
        output valid_pool,
        output end_pool
    );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pooling over a raster-ordered convolution map.
// A half-row line buffer keeps the pair maxima of each even row.
module max_pool_2x2 #(
    parameter int DATA_WIDTH = 8,
    parameter int CONV_SIZE  = 26
) (
    input  logic           clk,
    input  logic           global_rst,
    input  logic           ce,
    max_pool_2x2_if.slave  s
);
    localparam int POOL_OUT = CONV_SIZE / 2;
    localparam int CW = (CONV_SIZE > 1) ? $clog2(CONV_SIZE) : 1;
    localparam int KW = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;

    localparam logic [CW-1:0] LAST = CW'(CONV_SIZE - 1);
    localparam logic [CW-1:0] HLIM = CW'(POOL_OUT);
    localparam logic [CW-1:0] EDGE = CW'(2 * POOL_OUT - 1);

    logic [CW-1:0]         col;
    logic [CW-1:0]         row;
    logic [CW-1:0]         col_h;
    logic [CW-1:0]         row_h;
    logic [KW-1:0]         k;
    logic [DATA_WIDTH-1:0] h;
    logic [DATA_WIDTH-1:0] m;
    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] win_max;
    logic [DATA_WIDTH-1:0] lbuf [POOL_OUT];
    logic                  accept;
    logic                  in_region;
    logic                  frame_last;
    logic                  lbuf_we;

    assign accept = ce & s.in_valid;
    assign col_h  = col >> 1;
    assign row_h  = row >> 1;
    assign k      = col_h[KW-1:0];

    // Odd trailing column/row fall outside this window (floor pooling).
    assign in_region  = (col_h < HLIM) && (row_h < HLIM);
    assign frame_last = (row == EDGE) && (col == EDGE);

    assign m       = (s.in_data > h) ? s.in_data : h;
    assign top     = lbuf[k];
    assign win_max = (top > m) ? top : m;
    assign lbuf_we = global_rst & accept & in_region & col[0] & ~row[0];

    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf[k] <= m;
        end
    end

    always_ff @(posedge clk) begin
        if (!global_rst) begin
            col          <= '0;
            row          <= '0;
            h            <= '0;
            s.pool_out   <= '0;
            s.valid_pool <= 1'b0;
            s.end_pool   <= 1'b0;
        end else begin
            // Strobes are single-cycle regardless of ce.
            s.valid_pool <= 1'b0;
            s.end_pool   <= 1'b0;
            if (accept) begin
                if (col == LAST) begin
                    col <= '0;
                    row <= (row == LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (in_region) begin
                    if (!col[0]) begin
                        h <= s.in_data;
                    end else if (row[0]) begin
                        s.pool_out   <= win_max;
                        s.valid_pool <= 1'b1;
                        s.end_pool   <= frame_last;
                    end
                end
            end
        end
    end
endmodule
